// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_pkg
//  Description : Shared types, header field constants and SPI mode helper
//                for the clk-synchronous SPI slave to CSR bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

   // Transaction state: waiting for select, receiving header, moving data
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   // Header byte layout: bit 7 is the write flag, low bits carry the address
   localparam int C_HDR_W_BIT = 7;
   localparam int C_HDR_LEN   = 8;

   // Modes 0 and 3 sample on the rising sck edge, modes 1 and 2 on falling
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return cpol ~^ cpha;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_in_sync
//  Description : Multi-flop synchroniser for an asynchronous pin plus an edge
//                detector. rise = toggle & level, fall = toggle & ~level.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_in_sync #(
   parameter int SYNC_STAGES = 2,
   parameter bit RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic level,
   output logic toggle
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_level_d;

   // Shift the pin through the synchroniser and keep the previous level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync    <= {SYNC_STAGES{RESET_VALUE}};
         r_level_d <= RESET_VALUE;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], async_in};
         r_level_d <= r_sync[SYNC_STAGES-1];
      end
   end

   assign level  = r_sync[SYNC_STAGES-1];
   assign toggle = r_sync[SYNC_STAGES-1] ^ r_level_d;

endmodule
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_sync
//  Description : SPI slave to CSR bus bridge, oversampled in clk. An 8-bit
//                header (W flag + start address) is followed by a burst of
//                D_WIDTH-bit words, written to or read from consecutive CSRs.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync
   import spi_slave_pkg::*;
#(
   parameter int A_WIDTH     = 5,
   parameter int D_WIDTH     = 8,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter bit AUTO_INC    = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               chip_select,
   output logic [A_WIDTH-1:0] csr_address,
   output logic               csr_read,
   input  logic [D_WIDTH-1:0] csr_readdata,
   output logic               csr_write,
   output logic [D_WIDTH-1:0] csr_writedata,
   input  logic               sck,
   input  logic               nss,
   input  logic               sdi,
   output logic               sdo,
   output logic               sdo_en
);

   localparam int                 C_CNT_W       = $clog2(D_WIDTH);
   localparam logic [C_CNT_W-1:0] C_HDR_LAST    = C_CNT_W'(C_HDR_LEN - 1);
   localparam logic [C_CNT_W-1:0] C_WORD_LAST   = C_CNT_W'(D_WIDTH - 1);
   localparam bit                 C_SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

   logic                   w_sck_s;
   logic                   w_sck_toggle;
   logic                   w_nss_s;
   logic                   w_nss_toggle;
   logic                   w_sdi_s;
   logic                   w_sample;
   logic                   w_shift;
   logic                   w_nss_rise;
   logic                   w_nss_fall;
   logic [D_WIDTH-1:0]     w_word;

   logic [SYNC_STAGES-1:0] r_sdi_sync;
   state_t                 r_state;
   logic [C_CNT_W-1:0]     r_bit_cnt;
   logic [D_WIDTH-2:0]     r_rx_sr;
   logic [D_WIDTH-1:0]     r_tx_sr;
   logic [D_WIDTH-1:0]     r_tx_buf;
   logic                   r_rd_pend;
   logic                   r_is_write;

   // sck idles at CPOL so leaving reset never fakes an edge
   spi_in_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VALUE (CPOL)
   ) u_sck_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (sck),
      .level    (w_sck_s),
      .toggle   (w_sck_toggle)
   );

   // nss resets to the deselected level so chip_select starts low
   spi_in_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VALUE (1'b1)
   ) u_nss_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (nss),
      .level    (w_nss_s),
      .toggle   (w_nss_toggle)
   );

   // sdi uses the same depth as sck so data and clock stay aligned
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sdi_sync <= '0;
      end else begin
         r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      end
   end

   assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
   assign w_sample    = w_sck_toggle & (w_sck_s == C_SAMPLE_RISE);
   assign w_shift     = w_sck_toggle & (w_sck_s != C_SAMPLE_RISE);
   assign w_nss_rise  = w_nss_toggle &  w_nss_s;
   assign w_nss_fall  = w_nss_toggle & ~w_nss_s;
   assign w_word      = {r_rx_sr, w_sdi_s};
   assign chip_select = ~w_nss_s;
   assign sdo         = r_tx_sr[D_WIDTH-1];

   // Transaction FSM: header decode, word framing, CSR strobes and MISO shifter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_bit_cnt     <= '0;
         r_rx_sr       <= '0;
         r_tx_sr       <= '0;
         r_tx_buf      <= '0;
         r_rd_pend     <= 1'b0;
         r_is_write    <= 1'b0;
         csr_address   <= '0;
         csr_read      <= 1'b0;
         csr_write     <= 1'b0;
         csr_writedata <= '0;
         sdo_en        <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-armed below
         csr_read  <= 1'b0;
         csr_write <= 1'b0;

         // Read data arrives the clk after the strobe
         r_rd_pend <= csr_read;
         if (r_rd_pend) begin
            r_tx_buf <= csr_readdata;
         end

         // Writes advance the address once the strobe has been seen
         if (csr_write && AUTO_INC) begin
            csr_address <= csr_address + A_WIDTH'(1);
         end

         if (w_nss_rise) begin
            // Deselect aborts whatever is in flight; partial words are dropped
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_is_write  <= 1'b0;
            r_tx_sr     <= '0;
            csr_address <= '0;
            sdo_en      <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_nss_fall) begin
                     r_state   <= HDR;
                     r_bit_cnt <= '0;
                  end
               end

               HDR: begin
                  if (w_sample) begin
                     r_rx_sr <= w_word[D_WIDTH-2:0];
                     if (r_bit_cnt == C_HDR_LAST) begin
                        r_bit_cnt   <= '0;
                        r_state     <= DATA;
                        r_is_write  <= w_word[C_HDR_W_BIT];
                        csr_address <= w_word[A_WIDTH-1:0];
                        // A read burst fetches its first word straight away
                        csr_read    <= ~w_word[C_HDR_W_BIT];
                        sdo_en      <= ~w_word[C_HDR_W_BIT];
                     end else begin
                        r_bit_cnt <= r_bit_cnt + C_CNT_W'(1);
                     end
                  end
               end

               DATA: begin
                  // The shift edge that opens a word presents the fetched data
                  if (w_shift) begin
                     if (r_bit_cnt == '0) begin
                        r_tx_sr <= r_tx_buf;
                     end else begin
                        r_tx_sr <= {r_tx_sr[D_WIDTH-2:0], 1'b0};
                     end
                  end
                  if (w_sample) begin
                     r_rx_sr <= w_word[D_WIDTH-2:0];
                     if (r_bit_cnt == C_WORD_LAST) begin
                        r_bit_cnt <= '0;
                        if (r_is_write) begin
                           csr_writedata <= w_word;
                           csr_write     <= 1'b1;
                        end else begin
                           // Prefetch the next word at the advanced address
                           csr_read <= 1'b1;
                           if (AUTO_INC) begin
                              csr_address <= csr_address + A_WIDTH'(1);
                           end
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt + C_CNT_W'(1);
                     end
                  end
               end

               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
Second-generation SPI slave to CSR bridge, fully synchronous to the system clock.
- sck, nss and sdi are oversampled in clk; no logic runs on sck, and no CDC event modules are needed.
- Generalised over SPI mode (CPOL/CPHA), data width and address auto-increment, so one transaction can burst-read or burst-write consecutive CSRs.
- Sits between the external SPI pins and the CSR bus of the cdbus controller.

Parameters:
A_WIDTH, 5, CSR address width; legal range 1..7.
D_WIDTH, 8, data word width, MSB first; legal range 8..32.
CPOL, 0, sck idle level.
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
AUTO_INC, 1, 1 = address +1 (wraps modulo 2^A_WIDTH) after each data word; 0 = fixed address.
SYNC_STAGES, 2, synchroniser depth for sck, nss and sdi; minimum 2.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
chip_select  out  1  = !synchronised nss.
csr_address  out  A_WIDTH  CSR address.
csr_read  out  1  one-clk read strobe.
csr_readdata  in  D_WIDTH  read data, valid the clk after csr_read.
csr_write  out  1  one-clk write strobe.
csr_writedata  out  D_WIDTH  write data, valid while csr_write is high.
sck  in  1  SPI clock, asynchronous.
nss  in  1  SPI select, active low, asynchronous.
sdi  in  1  MOSI, asynchronous.
sdo  out  1  MISO data, = tx_sr MSB.
sdo_en  out  1  MISO output enable.

Behaviour:
- Reset values (asynchronous, reset_n low): all outputs 0, except chip_select = 0 with nss_s reset to 1. State = IDLE, shift registers 0, bit_cnt 0.
- Input sync and edge detect:
  - sck, nss, sdi each pass through SYNC_STAGES flops.
  - An edge on the synchronised sck is detected one clk after it arrives.
  - The sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1. The shift edge is the other one.
  - Timing requirement: sck half-period >= SYNC_STAGES+4 clk.
- Header (first 8 bits):
  - bit7 = W (1 = write).
  - bits[A_WIDTH-1:0] = start address; the remaining bits are ignored.
- States:
  - IDLE: nss_s high. Falling nss_s -> HDR, bit_cnt = 0.
  - HDR: on each sample edge, shift sdi into rx_sr. On the 8th sample, latch csr_address and the W flag, then -> DATA.
    - If W = 0, pulse csr_read in the next clk.
  - DATA: words of D_WIDTH bits, with bit_cnt counting 0..D_WIDTH-1 and wrapping.
  - Rising nss_s in any state -> IDLE on the next clk.
- Write path:
  - On the last sample of a word: csr_writedata = the full word (rx_sr plus sdi), and csr_write pulses for exactly 1 clk.
  - On the clk after csr_write, csr_address increments if AUTO_INC=1.
  - A partial word at nss rise is discarded; no csr_write is issued.
- Read path:
  - csr_readdata is captured into tx_buf on the clk after each csr_read.
  - On a shift edge with bit_cnt == 0: tx_sr = tx_buf. On other shift edges: tx_sr shifts left, inserting 0.
  - On the last sample of each DATA word: address increments (if AUTO_INC=1), then csr_read pulses to prefetch the next word.
  - One extra prefetch read is therefore issued at the end of a burst; this is a documented side effect.
  - sdo_en = 1 only in DATA with W = 0.
  - With CPHA=0, the first data bit is driven by the shift edge that ends the header.
- csr_read and csr_write are never asserted in the same clk, and never outside HDR/DATA.
- Abort handling:
  - nss rise mid-word: sdo_en drops within 1 clk of nss_s rising. No strobes are issued after that point. Address, W flag and bit_cnt are cleared on IDLE entry.
  - A strobe already scheduled in the clk of the abort still completes (1 clk wide).
- reset_n asserted mid-transaction: immediate return to reset values. After release, the block waits for an nss_s falling edge (IDLE) before accepting bits.
- An sck edge while nss_s is high is ignored.

Decomposition:
- Shared package spi_slave_pkg holds:
  - state encoding (IDLE/HDR/DATA);
  - header field constants: W bit index 7, header length 8;
  - the mode-to-edge selection function (CPOL, CPHA) -> sample_on_rise.
- One natural sub-module, spi_in_sync: a SYNC_STAGES synchroniser plus rise/fall detector, instantiated for sck and nss. sdi uses the synchroniser only.

Test Plan:
- Mode 0, D_WIDTH=8, AUTO_INC=1: header 0x83, then words 0xA5, 0x3C -> csr_write at addr 3 data 0xA5, then addr 4 data 0x3C; each strobe exactly 1 clk; no csr_read.
- Mode 3 read: header 0x05, CSR model returns 0x11 @5, 0x22 @6, 0x33 @7; clock 16 data bits -> sdo bytes 0x11, 0x22; csr_read at 5, 6, 7 (7 is the prefetch); sdo_en high only after the header.
- Mode 1 with D_WIDTH=16, AUTO_INC=0: header 0x9F, then words 0xBEEF, 0x1234 -> two writes to addr 31 (A_WIDTH=5) with data 0xBEEF then 0x1234.
- Address wrap: A_WIDTH=5, header 0x9F, 2 words -> writes at 31 then 0.
- Abort: nss rises after 5 bits of a write data word -> no csr_write; state IDLE; next transaction (header 0x81, 0x55) -> write at addr 1 data 0x55.
- reset_n low for 3 clk mid-read burst -> all outputs 0 immediately; next full read transaction returns correct data.
